// File: rtl/i2s_clock_ctrl.sv
// i2s_clock_ctrl: fractional-NCO bclk/lrclk generator that starts and stops the I2S bus on frame boundaries
module i2s_clock_ctrl #(
  parameter int CLK_RATE_HZ    = 50_000_000,
  parameter int SAMPLE_RATE_HZ = 48_000,
  parameter int ACC_W          = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        bclk,
  output logic        lrclk,
  output logic        frame_start,
  output logic        running,
  output logic [31:0] frame_count
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] STOPPING = 2'd2;
  localparam logic [63:0] INC64 = ((64'(SAMPLE_RATE_HZ) * 64'd128) << ACC_W) / 64'(CLK_RATE_HZ);
  localparam logic [ACC_W-1:0] INC = INC64[ACC_W-1:0];
  if (INC64 >= (64'd1 << (ACC_W - 1))) begin : g_rate_check
    $error("bclk rate must stay below clk/4");
  end
  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic [5:0]       bit_cnt;
  logic [5:0]       bit_nxt;
  logic             fall;
  logic             wrap;
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, INC};
    bit_nxt = bit_cnt + 6'd1;
    fall    = sum[ACC_W] & bclk;
    wrap    = fall & (bit_cnt == 6'd63);
  end
  assign running = state != IDLE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      acc         <= '0;
      bit_cnt     <= '0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= 1'b0;
      if (state == IDLE) begin
        if (enable) begin
          state       <= RUN;
          frame_start <= 1'b1;
          frame_count <= frame_count + 32'd1;
        end
      end else if (wrap && state == STOPPING && !enable) begin
        // stop lands on the final fall of the frame, leaving the bus parked low
        state   <= IDLE;
        acc     <= '0;
        bit_cnt <= '0;
        bclk    <= 1'b0;
        lrclk   <= 1'b0;
      end else begin
        acc   <= sum[ACC_W-1:0];
        state <= enable ? RUN : STOPPING;
        if (sum[ACC_W]) bclk <= ~bclk;
        if (fall) begin
          bit_cnt <= bit_nxt;
          lrclk   <= bit_nxt[5];
        end
        if (wrap) begin
          frame_start <= 1'b1;
          frame_count <= frame_count + 32'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_clock_ctrl.sv
// tb_i2s_clock_ctrl: randomized enable/reset stimulus against a time-based arithmetic model of the I2S clocks
module tb_i2s_clock_ctrl;
  localparam longint unsigned INC = 64'd527765581;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        bclk, lrclk, frame_start, running;
  logic [31:0] frame_count;
  int n_vec = 0;
  int n_bad = 0;
  i2s_clock_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .bclk(bclk), .lrclk(lrclk),
    .frame_start(frame_start), .running(running), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  // bclk toggles seen after k NCO cycles of one run: floor(k*INC/2^32)
  function automatic longint unsigned tog(input longint unsigned k);
    return (k * INC) >> 32;
  endfunction
  int              m_st = 0;
  longint unsigned m_n = 0;
  logic [31:0]     m_fc = '0;
  logic            m_fs = 1'b0;
  logic            m_rst = 1'b1;
  always @(posedge clk) begin
    longint unsigned t0, t1;
    logic w;
    m_rst = !reset;
    if (!reset) begin
      m_st = 0; m_n = 0; m_fc = '0; m_fs = 1'b0;
    end else if (m_st == 0) begin
      m_fs = enable;
      if (enable) begin m_st = 1; m_n = 0; m_fc++; end
    end else begin
      t0 = tog(m_n);
      t1 = tog(m_n + 1);
      w  = (t1 != t0) && (t1 % 2 == 0) && ((t1 / 2) % 64 == 0);
      if (w && m_st == 2 && !enable) begin
        m_st = 0; m_fs = 1'b0;
      end else begin
        m_n++;
        m_fs = w;
        if (w) m_fc++;
        m_st = enable ? 1 : 2;
      end
    end
  end
  logic    p_bc = 1'b0, p_lr = 1'b0, have = 1'b0, chk_period = 1'b0;
  longint  cyc = 0, last = 0;
  int      rises = 0, rises_hi = 0;
  always @(negedge clk) begin
    longint unsigned t;
    logic run;
    run = m_st != 0;
    t = tog(m_n);
    check("outs", {60'd0, bclk, lrclk, frame_start, running},
          {60'd0, run & (t % 2 == 1), run & (((t / 2) % 64) >= 32), m_fs, run});
    check("fcount", {32'd0, frame_count}, {32'd0, m_fc});
    if (!m_rst && lrclk !== p_lr) check("lr_on_fall", {62'd0, p_bc, bclk}, 64'd2);
    if (frame_start) check("fs_lr_low", {63'd0, lrclk}, 64'd0);
    if (bclk && !p_bc) begin rises++; if (lrclk) rises_hi++; end
    if (p_lr && !lrclk && !m_rst) begin
      if (chk_period && have) begin
        check("lr_period", {63'd0, (cyc - last == 1041) || (cyc - last == 1042)}, 64'd1);
        check("rises", 64'(rises), 64'd64);
        check("rises_hi", 64'(rises_hi), 64'd32);
      end
      have = chk_period; last = cyc; rises = 0; rises_hi = 0;
    end
    p_bc = bclk; p_lr = lrclk; cyc++;
  end
  initial begin
    repeat (10) @(negedge clk);
    check("rst_outs", {60'd0, bclk, lrclk, frame_start, running}, 64'd0);
    check("rst_fc", {32'd0, frame_count}, 64'd0);
    reset = 1'b1;
    chk_period = 1'b1;
    for (int k = 0; k < 12000 && frame_count != 10; k++) @(negedge clk);
    check("frames10", {32'd0, frame_count}, 64'd10);
    repeat (1100) @(negedge clk);
    chk_period = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(50, 1500)) @(negedge clk);
      enable = 1'b0;
      if (i % 2 == 1) begin
        repeat ($urandom_range(5, 300)) @(negedge clk);
        enable = 1'b1;
      end else begin
        for (int k = 0; k < 1200 && running; k++) @(negedge clk);
        check("stop_idle", {63'd0, running}, 64'd0);
        check("stop_bus", {62'd0, bclk, lrclk}, 64'd0);
        repeat ($urandom_range(1, 50)) @(negedge clk);
        enable = 1'b1;
      end
    end
    for (int k = 0; k < 1200 && !lrclk; k++) @(negedge clk);
    check("lr_hi_pre_rst", {63'd0, lrclk}, 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid", {28'd0, bclk, lrclk, frame_start, running, frame_count}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("restart", {60'd0, bclk, lrclk, frame_start, running}, 64'd3);
    repeat (2500) @(negedge clk);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 999) < 3) enable = ~enable;
    end
    enable = 1'b1;
    repeat (200) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
